srclist_split: RTL and testbench

Fan-out unit for carpooled (merged) packets. A merged flit's `SRC_LIST` bitmask names every requester that was coalesced onto it. This block sits at the memory-controller ejection side, inverse to the in-router merge stage. It takes one merged descriptor at a time and emits one unicast descriptor per set bit, lowest source index first, so each original requester gets its own reply.

---
 rtl/srclist_split_pkg.sv | 17 +
 rtl/srclist_split_lsb_prio_enc.sv | 28 ++
 rtl/srclist_split.sv | 141 ++++++++++++++
 tb/tb_srclist_split.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srclist_split_pkg.sv
// Shared definitions for the merged-packet fan-out unit: default widths
// matching the global width set and the splitter FSM state encoding.
package srclist_split_pkg;

    // Default widths: 16 nodes, 4-bit node index, 32-bit address, 2-bit flit ID.
    localparam int SRC_LIST_WIDTH_D = 16;
    localparam int DST_WIDTH_D      = 4;
    localparam int MEM_ADDR_WIDTH_D = 32;
    localparam int NUM_FLIT_WIDTH_D = 2;

    // IDLE waits for a merged descriptor, SPLIT walks its requester mask.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

endpackage

// File: rtl/srclist_split_lsb_prio_enc.sv
// Lowest-set-bit priority encoder. Returns the index of the least
// significant set bit (0 for an all-zero vector) and flags vectors with at
// most one bit set, which the splitter uses to mark the final unicast.
module lsb_prio_enc
    import srclist_split_pkg::*;
#(
    parameter int SRC_LIST_WIDTH = SRC_LIST_WIDTH_D,
    parameter int DST_WIDTH      = DST_WIDTH_D
) (
    input  logic [SRC_LIST_WIDTH-1:0] vec,
    output logic [DST_WIDTH-1:0]      idx,
    output logic                      onehot_or_zero
);

    // Scan from the top down so the lowest set bit is the last writer and wins.
    always_comb begin
        idx = '0;
        for (int i = SRC_LIST_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = DST_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only if at most one bit was set.
    assign onehot_or_zero = ((vec & (vec - SRC_LIST_WIDTH'(1))) == '0);

endmodule

// File: rtl/srclist_split.sv
// Fan-out unit for carpooled packets. Accepts one merged descriptor at a
// time and emits one unicast descriptor per requester named in its source
// mask, lowest index first. A descriptor with an empty mask is dropped and
// reported through a one-cycle err_empty pulse.
module srclist_split
    import srclist_split_pkg::*;
#(
    parameter int SRC_LIST_WIDTH = SRC_LIST_WIDTH_D,
    parameter int DST_WIDTH      = DST_WIDTH_D,
    parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH_D,
    parameter int FLITID_WIDTH   = NUM_FLIT_WIDTH_D
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SRC_LIST_WIDTH-1:0] in_srcList,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [FLITID_WIDTH-1:0]   in_flitID,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DST_WIDTH-1:0]      out_dst,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [FLITID_WIDTH-1:0]   out_flitID,
    output logic                      out_last,
    output logic [DST_WIDTH:0]        out_fanout,
    output logic                      err_empty
);

    split_state_t              state_q;
    split_state_t              state_d;

    logic [SRC_LIST_WIDTH-1:0] pending;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [FLITID_WIDTH-1:0]   flitID_q;
    logic [DST_WIDTH:0]        fanout_q;
    logic                      err_q;

    logic [DST_WIDTH-1:0]      enc_idx;
    logic                      enc_single;
    logic [DST_WIDTH:0]        in_popcnt;
    logic                      in_nonzero;
    logic                      accept;
    logic                      load;
    logic                      fire;

    lsb_prio_enc #(
        .SRC_LIST_WIDTH (SRC_LIST_WIDTH),
        .DST_WIDTH      (DST_WIDTH)
    ) u_enc (
        .vec            (pending),
        .idx            (enc_idx),
        .onehot_or_zero (enc_single)
    );

    // Popcount of the incoming mask; one extra bit so a full mask fits.
    always_comb begin
        in_popcnt = '0;
        for (int i = 0; i < SRC_LIST_WIDTH; i++) begin
            in_popcnt = in_popcnt + (DST_WIDTH + 1)'(in_srcList[i]);
        end
    end

    assign in_nonzero = (in_srcList != '0);
    assign accept     = in_valid & in_ready;
    assign load       = accept & in_nonzero;
    assign fire       = out_valid & out_ready;

    // Next state and handshake outputs; in_ready never looks at in_valid.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_nonzero) begin
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                out_valid = 1'b1;
                out_last  = enc_single;
                // The final beat frees the slot, so a new descriptor can be
                // taken in the same cycle and splitting continues bubble-free.
                in_ready  = out_ready & enc_single;
                if (out_ready && enc_single) begin
                    state_d = (in_valid && in_nonzero) ? ST_SPLIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor latch and per-beat retirement of the lowest pending requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            addr_q   <= '0;
            flitID_q <= '0;
            fanout_q <= '0;
        end else if (load) begin
            pending  <= in_srcList;
            addr_q   <= in_addr;
            flitID_q <= in_flitID;
            fanout_q <= in_popcnt;
        end else if (fire) begin
            pending  <= pending & (pending - SRC_LIST_WIDTH'(1));
        end
    end

    // Empty-mask descriptors are swallowed; flag them for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~in_nonzero;
        end
    end

    assign out_dst    = enc_idx;
    assign out_addr   = addr_q;
    assign out_flitID = flitID_q;
    assign out_fanout = fanout_q;
    assign err_empty  = err_q;

endmodule

// File: tb/tb_srclist_split.sv
// Scoreboard bench for srclist_split: a reference model expands each
// accepted descriptor into its expected unicast beats, and a separate
// monitor pops and compares every beat the DUT hands over.
module tb_srclist_split;

    typedef struct packed {
        logic [3:0]  dst;
        logic [31:0] addr;
        logic [1:0]  fid;
        logic        last;
        logic [4:0]  fan;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_srcList;
    logic [31:0] in_addr;
    logic [1:0]  in_flitID;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_dst;
    logic [31:0] out_addr;
    logic [1:0]  out_flitID;
    logic        out_last;
    logic [4:0]  out_fanout;
    logic        err_empty;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_err = 0;
    int    obs_err = 0;
    int    cyc     = 0;
    logic  rdy_rand = 1'b0;

    beat_t exp_q[$];
    int    log_dst[$];
    int    log_cyc[$];

    srclist_split dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_srcList (in_srcList),
        .in_addr    (in_addr),
        .in_flitID  (in_flitID),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dst    (out_dst),
        .out_addr   (out_addr),
        .out_flitID (out_flitID),
        .out_last   (out_last),
        .out_fanout (out_fanout),
        .err_empty  (err_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one beat per set bit, ascending; last beat is the
    // highest set bit; fanout is the number of set bits.
    function automatic void model_push(input logic [15:0] l, input logic [31:0] a, input logic [1:0] f);
        beat_t b;
        if (l == 16'h0) begin
            exp_err++;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (l[i]) begin
                b.dst  = 4'(i);
                b.addr = a;
                b.fid  = f;
                b.last = ((l >> (i + 1)) == 16'h0);
                b.fan  = 5'($countones(l));
                exp_q.push_back(b);
            end
        end
    endfunction

    // Called just after a falling edge; returns just after the falling edge
    // that follows acceptance, with in_valid still asserted.
    task automatic send(input logic [15:0] l, input logic [31:0] a, input logic [1:0] f, output int waits);
        in_valid   = 1'b1;
        in_srcList = l;
        in_addr    = a;
        in_flitID  = f;
        waits      = -1;
        for (int w = 0; w < 200; w++) begin
            #1;
            if (in_ready) begin
                model_push(l, a, f);
                waits = w;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never rose for list 0x%0h", l);
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares every handshaken beat and holds the payload steady
    // across stall cycles.
    initial begin
        beat_t cur;
        beat_t held;
        beat_t e;
        logic  stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                stalled = 1'b0;
                continue;
            end
            cur = '{out_dst, out_addr, out_flitID, out_last, out_fanout};
            if (out_valid && stalled) check("stall_stable", 64'(cur), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(cur), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                log_dst.push_back(int'(out_dst));
                log_cyc.push_back(cyc);
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = cur;
            end else begin
                stalled = 1'b0;
            end
            if (err_empty) obs_err++;
        end
    end

    initial begin
        int w;
        int w2;
        int gap;
        int r;
        logic [15:0] l;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_srcList = '0;
        in_addr    = '0;
        in_flitID  = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready),   64'd1);
        check("rst_out_valid", 64'(out_valid),  64'd0);
        check("rst_out_dst",   64'(out_dst),    64'd0);
        check("rst_out_last",  64'(out_last),   64'd0);
        check("rst_fanout",    64'(out_fanout), 64'd0);
        check("rst_err",       64'(err_empty),  64'd0);
        @(negedge clk);

        // Single-bit list: one beat, one cycle after acceptance.
        send(16'h0001, 32'h1000, 2'd1, w);
        in_valid = 1'b0;
        #1;
        check("single_valid",  64'(out_valid),  64'd1);
        check("single_dst",    64'(out_dst),    64'd0);
        check("single_last",   64'(out_last),   64'd1);
        check("single_addr",   64'(out_addr),   64'h1000);
        check("single_fid",    64'(out_flitID), 64'd1);
        check("single_fanout", 64'(out_fanout), 64'd1);
        @(negedge clk);
        #1;
        check("single_idle_valid", 64'(out_valid), 64'd0);
        check("single_idle_ready", 64'(in_ready),  64'd1);
        drain("single_drain");

        // Multi-bit list at full rate.
        log_dst.delete();
        log_cyc.delete();
        send(16'hA005, 32'hCAFE_0000, 2'd2, w);
        drain("a005_drain");
        check("a005_beats", 64'(log_dst.size()), 64'd4);
        if (log_dst.size() == 4) begin
            check("a005_dst2",  64'(log_dst[2]), 64'd13);
            check("a005_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
            check("a005_gap23", 64'(log_cyc[3] - log_cyc[2]), 64'd1);
        end

        // Same list with three stall cycles on the second beat.
        log_dst.delete();
        send(16'hA005, 32'h0BAD_F00D, 2'd3, w);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("stall_dst_0", 64'(out_dst), 64'd2);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("stall_vld", 64'(out_valid), 64'd1);
            check("stall_dst", 64'(out_dst),   64'd2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain("stall_drain");
        check("stall_beats", 64'(log_dst.size()), 64'd4);

        // Back-to-back descriptors with no bubble.
        log_dst.delete();
        log_cyc.delete();
        send(16'h0003, 32'h2000, 2'd0, w);
        send(16'h0010, 32'h3000, 2'd1, w2);
        check("b2b_wait", 64'(w2), 64'd1);
        drain("b2b_drain");
        check("b2b_beats", 64'(log_dst.size()), 64'd3);
        if (log_dst.size() == 3) begin
            check("b2b_dst2",  64'(log_dst[2]), 64'd4);
            check("b2b_span",  64'(log_cyc[2] - log_cyc[0]), 64'd2);
        end

        // Empty list: accepted, dropped, flagged for exactly one cycle.
        send(16'h0000, 32'h4000, 2'd0, w);
        in_valid = 1'b0;
        check("empty_wait", 64'(w), 64'd0);
        #1;
        check("empty_err",   64'(err_empty), 64'd1);
        check("empty_noout", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("empty_err_clr", 64'(err_empty), 64'd0);
        @(negedge clk);

        // Full mask, reset asynchronously mid-split after five beats.
        send(16'hFFFF, 32'h5000, 2'd2, w);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid",   64'(out_valid), 64'd0);
        check("arst_left",    64'(exp_q.size()), 64'd11);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_idle_ready", 64'(in_ready),   64'd1);
        check("arst_idle_dst",   64'(out_dst),    64'd0);
        check("arst_idle_fan",   64'(out_fanout), 64'd0);
        @(negedge clk);
        log_dst.delete();
        send(16'h0100, 32'h6000, 2'd1, w);
        drain("arst_next_drain");
        check("arst_next_beats", 64'(log_dst.size()), 64'd1);
        if (log_dst.size() == 1) check("arst_next_dst", 64'(log_dst[0]), 64'd8);

        // Randomised traffic with random downstream backpressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0:       l = 16'h0000;
                1:       l = 16'h0001 << $urandom_range(0, 15);
                2:       l = 16'hFFFF;
                default: l = 16'($urandom);
            endcase
            send(l, $urandom, 2'($urandom_range(0, 3)), w);
            gap = int'($urandom_range(0, 2));
            if (gap != 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        @(negedge clk);
        @(negedge clk);
        check("err_count", 64'(obs_err), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Random downstream backpressure during the randomised phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected beats left", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
